// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI4-Lite bundle shared by the two requester ports and the DRAM master port.
//   master modport : drives AW/W/AR payload+valid and B/R ready (a requester, or
//                    the arbiter facing DRAM).
//   slave modport  : the mirror image (the arbiter facing a requester, or DRAM).
interface axi_lite_arbiter_2to1_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BYTE_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// 2:1 AXI4-Lite arbiter sharing one DRAM master port between the Microwatt core
// (s0) and the PS loader/debug master (s1). Read and write sides have their own
// round-robin arbiter, each allowing one outstanding transaction.
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   s0, s1              requester ports (slave modport)
//   m                   DRAM-facing port (master modport)
//   wr_grant / rd_grant current owner of the write / read path (valid when busy)
//   wr_busy / rd_busy   arbiter not idle
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    axi_lite_arbiter_2to1_if.slave         s0,
    axi_lite_arbiter_2to1_if.slave         s1,
    axi_lite_arbiter_2to1_if.master        m,
    output logic                           wr_grant,
    output logic                           rd_grant,
    output logic                           wr_busy,
    output logic                           rd_busy
);
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    // Requester signals gathered into arrays indexed by requester number so the
    // grant register can select directly.
    logic [1:0]                 awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s;
    logic [1:0][ADDR_WIDTH-1:0] awaddr_s, araddr_s;
    logic [1:0][2:0]            awprot_s, arprot_s;
    logic [1:0][DATA_WIDTH-1:0] wdata_s;
    logic [1:0][BYTE_WIDTH-1:0] wstrb_s;

    logic [1:0]                 awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
    logic [1:0][1:0]            bresp_s, rresp_s;
    logic [1:0][DATA_WIDTH-1:0] rdata_s;

    assign awvalid_s = {s1.awvalid, s0.awvalid};
    assign awaddr_s  = {s1.awaddr,  s0.awaddr};
    assign awprot_s  = {s1.awprot,  s0.awprot};
    assign wvalid_s  = {s1.wvalid,  s0.wvalid};
    assign wdata_s   = {s1.wdata,   s0.wdata};
    assign wstrb_s   = {s1.wstrb,   s0.wstrb};
    assign bready_s  = {s1.bready,  s0.bready};
    assign arvalid_s = {s1.arvalid, s0.arvalid};
    assign araddr_s  = {s1.araddr,  s0.araddr};
    assign arprot_s  = {s1.arprot,  s0.arprot};
    assign rready_s  = {s1.rready,  s0.rready};

    assign s0.awready = awready_s[0];
    assign s1.awready = awready_s[1];
    assign s0.wready  = wready_s[0];
    assign s1.wready  = wready_s[1];
    assign s0.bvalid  = bvalid_s[0];
    assign s1.bvalid  = bvalid_s[1];
    assign s0.bresp   = bresp_s[0];
    assign s1.bresp   = bresp_s[1];
    assign s0.arready = arready_s[0];
    assign s1.arready = arready_s[1];
    assign s0.rvalid  = rvalid_s[0];
    assign s1.rvalid  = rvalid_s[1];
    assign s0.rresp   = rresp_s[0];
    assign s1.rresp   = rresp_s[1];
    assign s0.rdata   = rdata_s[0];
    assign s1.rdata   = rdata_s[1];

    // ------------------------------------------------------------------
    // Write arbiter
    // ------------------------------------------------------------------
    w_state_t w_state, w_next;
    logic     wr_gnt, wr_gnt_next;
    logic     wr_rr, wr_rr_next;
    logic     aw_done, aw_done_next;
    logic     w_done, w_done_next;
    logic     m_awvalid, m_wvalid, m_bready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            wr_gnt  <= 1'b0;
            wr_rr   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_next;
            wr_gnt  <= wr_gnt_next;
            wr_rr   <= wr_rr_next;
            aw_done <= aw_done_next;
            w_done  <= w_done_next;
        end
    end

    always_comb begin
        w_next       = w_state;
        wr_gnt_next  = wr_gnt;
        wr_rr_next   = wr_rr;
        aw_done_next = aw_done;
        w_done_next  = w_done;
        m_awvalid    = 1'b0;
        m_wvalid     = 1'b0;
        m_bready     = 1'b0;
        awready_s    = '0;
        wready_s     = '0;
        bvalid_s     = '0;
        bresp_s      = '0;
        unique case (w_state)
            W_IDLE: begin
                // Grant is decided only from AW; a lone W waits unacknowledged.
                if (|awvalid_s) begin
                    wr_gnt_next = (&awvalid_s) ? wr_rr : awvalid_s[1];
                    w_next      = W_XFER;
                end
            end
            W_XFER: begin
                // AW and W complete independently; the done flags mask the
                // channel that has already handshaken.
                m_awvalid         = awvalid_s[wr_gnt] & ~aw_done;
                awready_s[wr_gnt] = m.awready & ~aw_done;
                m_wvalid          = wvalid_s[wr_gnt] & ~w_done;
                wready_s[wr_gnt]  = m.wready & ~w_done;
                aw_done_next      = aw_done | (m_awvalid & m.awready);
                w_done_next       = w_done | (m_wvalid & m.wready);
                if (aw_done_next && w_done_next) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    w_next       = W_RESP;
                end
            end
            W_RESP: begin
                m_bready         = bready_s[wr_gnt];
                bvalid_s[wr_gnt] = m.bvalid;
                bresp_s[wr_gnt]  = m.bresp;
                if (m.bvalid && m_bready) begin
                    wr_rr_next = ~wr_gnt;
                    w_next     = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign m.awvalid = m_awvalid;
    assign m.wvalid  = m_wvalid;
    assign m.bready  = m_bready;
    assign m.awaddr  = (w_state == W_XFER) ? awaddr_s[wr_gnt] : '0;
    assign m.awprot  = (w_state == W_XFER) ? awprot_s[wr_gnt] : '0;
    assign m.wdata   = (w_state == W_XFER) ? wdata_s[wr_gnt]  : '0;
    assign m.wstrb   = (w_state == W_XFER) ? wstrb_s[wr_gnt]  : '0;
    assign wr_grant  = wr_gnt;
    assign wr_busy   = (w_state != W_IDLE);

    // ------------------------------------------------------------------
    // Read arbiter
    // ------------------------------------------------------------------
    r_state_t r_state, r_next;
    logic     rd_gnt, rd_gnt_next;
    logic     rd_rr, rd_rr_next;
    logic     m_arvalid, m_rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            rd_gnt  <= 1'b0;
            rd_rr   <= 1'b0;
        end else begin
            r_state <= r_next;
            rd_gnt  <= rd_gnt_next;
            rd_rr   <= rd_rr_next;
        end
    end

    always_comb begin
        r_next      = r_state;
        rd_gnt_next = rd_gnt;
        rd_rr_next  = rd_rr;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        arready_s   = '0;
        rvalid_s    = '0;
        rresp_s     = '0;
        rdata_s     = '0;
        unique case (r_state)
            R_IDLE: begin
                if (|arvalid_s) begin
                    rd_gnt_next = (&arvalid_s) ? rd_rr : arvalid_s[1];
                    r_next      = R_ADDR;
                end
            end
            R_ADDR: begin
                m_arvalid         = arvalid_s[rd_gnt];
                arready_s[rd_gnt] = m.arready;
                if (m_arvalid && m.arready)
                    r_next = R_DATA;
            end
            R_DATA: begin
                m_rready         = rready_s[rd_gnt];
                rvalid_s[rd_gnt] = m.rvalid;
                rresp_s[rd_gnt]  = m.rresp;
                rdata_s[rd_gnt]  = m.rdata;
                if (m.rvalid && m_rready) begin
                    rd_rr_next = ~rd_gnt;
                    r_next     = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign m.arvalid = m_arvalid;
    assign m.rready  = m_rready;
    assign m.araddr  = (r_state == R_ADDR) ? araddr_s[rd_gnt] : '0;
    assign m.arprot  = (r_state == R_ADDR) ? arprot_s[rd_gnt] : '0;
    assign rd_grant  = rd_gnt;
    assign rd_busy   = (r_state != R_IDLE);
endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
module tb_axi_lite_arbiter_2to1;
    logic aclk = 1'b0;
    logic aresetn;
    logic wr_grant, rd_grant, wr_busy, rd_busy;
    int   vectors = 0;
    int   errors  = 0;

    axi_lite_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s0_if ();
    axi_lite_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s1_if ();
    axi_lite_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) m_if ();

    axi_lite_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s0      (s0_if),
        .s1      (s1_if),
        .m       (m_if),
        .wr_grant(wr_grant),
        .rd_grant(rd_grant),
        .wr_busy (wr_busy),
        .rd_busy (rd_busy)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit later.
    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    initial begin
        {s0_if.awaddr, s0_if.awprot, s0_if.awvalid, s0_if.wdata, s0_if.wstrb, s0_if.wvalid,
         s0_if.bready, s0_if.araddr, s0_if.arprot, s0_if.arvalid, s0_if.rready} = '0;
        {s1_if.awaddr, s1_if.awprot, s1_if.awvalid, s1_if.wdata, s1_if.wstrb, s1_if.wvalid,
         s1_if.bready, s1_if.araddr, s1_if.arprot, s1_if.arvalid, s1_if.rready} = '0;
        {m_if.awready, m_if.wready, m_if.bresp, m_if.bvalid, m_if.arready,
         m_if.rdata, m_if.rresp, m_if.rvalid} = '0;
        aresetn = 1'b1;
        #2 aresetn = 1'b0;

        // ---- reset state
        cyc(2);
        #1;
        check("rst_m_awvalid", 64'(m_if.awvalid), 64'd0);
        check("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
        check("rst_m_bready",  64'(m_if.bready),  64'd0);
        check("rst_m_rready",  64'(m_if.rready),  64'd0);
        check("rst_busy",      64'({wr_busy, rd_busy}),   64'd0);
        check("rst_grant",     64'({wr_grant, rd_grant}), 64'd0);
        cyc(1);
        aresetn = 1'b1;

        // ---- s0 single write
        cyc(1);
        s0_if.awaddr = 32'h0000_1000; s0_if.awvalid = 1'b1;
        s0_if.wdata = 64'h1122334455667788; s0_if.wstrb = 8'hFF; s0_if.wvalid = 1'b1;
        s0_if.bready = 1'b1; m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1;
        check("w1_idle_awvalid", 64'(m_if.awvalid), 64'd0);
        check("w1_idle_awready", 64'(s0_if.awready), 64'd0);
        check("w1_idle_busy",    64'(wr_busy), 64'd0);
        cyc(1);
        #1;
        check("w1_m_awvalid", 64'(m_if.awvalid), 64'd1);
        check("w1_m_awaddr",  64'(m_if.awaddr), 64'h1000);
        check("w1_m_wdata",   m_if.wdata, 64'h1122334455667788);
        check("w1_m_wstrb",   64'(m_if.wstrb), 64'hFF);
        check("w1_s0_ready",  64'({s0_if.awready, s0_if.wready}), 64'b11);
        check("w1_s1_ready",  64'({s1_if.awready, s1_if.wready}), 64'b00);
        check("w1_grant",     64'(wr_grant), 64'd0);
        check("w1_busy",      64'(wr_busy), 64'd1);
        cyc(1);
        s0_if.awvalid = 1'b0; s0_if.wvalid = 1'b0;
        m_if.bvalid = 1'b1; m_if.bresp = 2'b00;
        #1;
        check("w1_resp_awvalid", 64'(m_if.awvalid), 64'd0);
        check("w1_s0_bvalid",    64'(s0_if.bvalid), 64'd1);
        check("w1_s0_bresp",     64'(s0_if.bresp), 64'd0);
        check("w1_s1_bvalid",    64'(s1_if.bvalid), 64'd0);
        check("w1_m_bready",     64'(m_if.bready), 64'd1);
        cyc(1);
        m_if.bvalid = 1'b0;
        #1;
        check("w1_done_busy", 64'(wr_busy), 64'd0);

        // ---- simultaneous reads, round-robin alternation s0,s1,s0
        s0_if.araddr = 32'h100; s0_if.arvalid = 1'b1; s0_if.rready = 1'b1;
        s1_if.araddr = 32'h200; s1_if.arvalid = 1'b1; s1_if.rready = 1'b1;
        m_if.arready = 1'b1;
        cyc(1);
        #1;
        check("r1_grant",     64'(rd_grant), 64'd0);
        check("r1_m_araddr",  64'(m_if.araddr), 64'h100);
        check("r1_arready",   64'({s1_if.arready, s0_if.arready}), 64'b01);
        cyc(1);
        s0_if.arvalid = 1'b0;
        m_if.rvalid = 1'b1; m_if.rdata = 64'hA0;
        #1;
        check("r1_s0_rvalid", 64'(s0_if.rvalid), 64'd1);
        check("r1_s0_rdata",  s0_if.rdata, 64'hA0);
        check("r1_s1_rvalid", 64'(s1_if.rvalid), 64'd0);
        check("r1_s1_rdata",  s1_if.rdata, 64'h0);
        cyc(1);
        m_if.rvalid = 1'b0;
        s0_if.arvalid = 1'b1;
        cyc(1);
        #1;
        check("r2_grant",    64'(rd_grant), 64'd1);
        check("r2_m_araddr", 64'(m_if.araddr), 64'h200);
        cyc(1);
        s1_if.arvalid = 1'b0;
        m_if.rvalid = 1'b1; m_if.rdata = 64'hB0;
        #1;
        check("r2_s1_rdata",  s1_if.rdata, 64'hB0);
        check("r2_s0_rvalid", 64'(s0_if.rvalid), 64'd0);
        cyc(1);
        m_if.rvalid = 1'b0;
        cyc(1);
        #1;
        check("r3_grant",    64'(rd_grant), 64'd0);
        check("r3_m_araddr", 64'(m_if.araddr), 64'h100);
        cyc(1);
        s0_if.arvalid = 1'b0;
        m_if.rvalid = 1'b1; m_if.rdata = 64'hC0;
        cyc(1);
        m_if.rvalid = 1'b0;
        #1;
        check("r3_done_busy", 64'(rd_busy), 64'd0);

        // ---- s1 W three cycles ahead of AW, AW ready held off
        m_if.awready = 1'b0; m_if.wready = 1'b1;
        s1_if.wvalid = 1'b1; s1_if.wdata = 64'hCAFE_F00D_DEAD_BEEF; s1_if.wstrb = 8'h0F;
        s1_if.bready = 1'b1;
        cyc(3);
        #1;
        check("w2_early_wvalid", 64'(m_if.wvalid), 64'd0);
        check("w2_early_wready", 64'(s1_if.wready), 64'd0);
        s1_if.awvalid = 1'b1; s1_if.awaddr = 32'h2000; s1_if.awprot = 3'b010;
        cyc(1);
        #1;
        check("w2_grant",     64'(wr_grant), 64'd1);
        check("w2_m_wdata",   m_if.wdata, 64'hCAFE_F00D_DEAD_BEEF);
        check("w2_m_wstrb",   64'(m_if.wstrb), 64'h0F);
        check("w2_m_awprot",  64'(m_if.awprot), 64'b010);
        check("w2_s1_ready",  64'({s1_if.awready, s1_if.wready}), 64'b01);
        cyc(1);
        s1_if.wvalid = 1'b0;
        #1;
        check("w2_wdone_wvalid",  64'(m_if.wvalid), 64'd0);
        check("w2_wdone_awvalid", 64'(m_if.awvalid), 64'd1);
        cyc(2);
        #1;
        check("w2_wait_bready", 64'(m_if.bready), 64'd0);
        check("w2_wait_aw",     64'(m_if.awvalid), 64'd1);
        m_if.awready = 1'b1;
        #1;
        check("w2_s1_awready", 64'(s1_if.awready), 64'd1);
        cyc(1);
        s1_if.awvalid = 1'b0; m_if.awready = 1'b0;
        m_if.bvalid = 1'b1; m_if.bresp = 2'b10;
        #1;
        check("w2_resp_awvalid", 64'(m_if.awvalid), 64'd0);
        check("w2_s1_bresp",     64'(s1_if.bresp), 64'd2);
        check("w2_s0_bvalid",    64'(s0_if.bvalid), 64'd0);
        cyc(1);
        m_if.bvalid = 1'b0; m_if.bresp = 2'b00;

        // ---- concurrent s0 read and s1 write
        s0_if.arvalid = 1'b1; s0_if.araddr = 32'h300;
        s1_if.awvalid = 1'b1; s1_if.awaddr = 32'h3000; s1_if.awprot = 3'b000;
        s1_if.wvalid = 1'b1; s1_if.wdata = 64'h55; s1_if.wstrb = 8'h01;
        m_if.arready = 1'b1; m_if.awready = 1'b1; m_if.wready = 1'b1;
        cyc(1);
        #1;
        check("c_grants", 64'({rd_grant, wr_grant}), 64'b01);
        check("c_busy",   64'({rd_busy, wr_busy}),   64'b11);
        cyc(1);
        s0_if.arvalid = 1'b0; s1_if.awvalid = 1'b0; s1_if.wvalid = 1'b0;
        s0_if.rready = 1'b0;
        m_if.rvalid = 1'b1; m_if.rdata = 64'hD0D0; m_if.bvalid = 1'b1;
        s1_if.arvalid = 1'b1; s1_if.araddr = 32'h400;
        #1;
        check("c_s0_rvalid", 64'(s0_if.rvalid), 64'd1);
        check("c_s1_bvalid", 64'(s1_if.bvalid), 64'd1);
        check("c_m_rready",  64'(m_if.rready), 64'd0);

        // ---- read backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            m_if.bvalid = 1'b0;
            #1;
            check("bp_rdata",   s0_if.rdata, 64'hD0D0);
            check("bp_arvalid", 64'(m_if.arvalid), 64'd0);
            check("bp_rd_busy", 64'(rd_busy), 64'd1);
        end
        check("bp_wr_idle", 64'(wr_busy), 64'd0);
        s0_if.rready = 1'b1;
        #1;
        check("bp_m_rready", 64'(m_if.rready), 64'd1);
        cyc(1);
        m_if.rvalid = 1'b0;
        cyc(1);
        #1;
        check("bp_next_grant",  64'(rd_grant), 64'd1);
        check("bp_next_araddr", 64'(m_if.araddr), 64'h400);
        cyc(1);
        s1_if.arvalid = 1'b0;
        m_if.rvalid = 1'b1; m_if.rdata = 64'hE0;
        cyc(1);
        m_if.rvalid = 1'b0;

        // ---- reset during W_XFER: first a s0 write so wr_rr points at s1
        s0_if.awvalid = 1'b1; s0_if.awaddr = 32'h5000; s0_if.wvalid = 1'b1;
        cyc(1);
        cyc(1);
        s0_if.awvalid = 1'b0; s0_if.wvalid = 1'b0; m_if.bvalid = 1'b1;
        cyc(1);
        m_if.bvalid = 1'b0;
        s0_if.awvalid = 1'b1; s0_if.awaddr = 32'h6000; s0_if.wvalid = 1'b1;
        s1_if.awvalid = 1'b1; s1_if.awaddr = 32'h7000; s1_if.wvalid = 1'b1;
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        cyc(1);
        #1;
        check("rx_pre_grant", 64'(wr_grant), 64'd1);
        m_if.awready = 1'b1;
        #1;
        check("rx_pre_awready", 64'(s1_if.awready), 64'd1);
        aresetn = 1'b0;
        #1;
        check("rx_awready",  64'(s1_if.awready), 64'd0);
        check("rx_m_valids", 64'({m_if.awvalid, m_if.wvalid}), 64'd0);
        check("rx_busy",     64'(wr_busy), 64'd0);
        check("rx_grant",    64'(wr_grant), 64'd0);
        m_if.awready = 1'b0;
        cyc(1);
        aresetn = 1'b1;
        cyc(1);
        #1;
        check("rx_after_grant",  64'(wr_grant), 64'd0);
        check("rx_after_awaddr", 64'(m_if.awaddr), 64'h6000);
        check("rx_after_busy",   64'(wr_busy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
